// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined Urdhva-Tiryagbhyam multiplier with valid/ready flow control
// and a per-beat signed/unsigned mode. vedic_core is the recursive unsigned array.

module vedic_core #(
    parameter int N = 2
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    generate
        if (N == 2) begin : g_cell
            // 2x2 vertical-and-crosswise cell: AND products folded by two half adders
            logic x0, x1, hi, c1;
            assign x0   = a[1] & b[0];
            assign x1   = a[0] & b[1];
            assign hi   = a[1] & b[1];
            assign c1   = x0 & x1;
            assign p[0] = a[0] & b[0];
            assign p[1] = x0 ^ x1;
            assign p[2] = hi ^ c1;
            assign p[3] = hi & c1;
        end else begin : g_split
            localparam int M = N / 2;
            logic [N-1:0]   ll, lh, hl, hh;
            logic [2*N-1:0] mid;
            vedic_core #(.N(M)) u_ll (.a(a[M-1:0]), .b(b[M-1:0]), .p(ll));
            vedic_core #(.N(M)) u_lh (.a(a[M-1:0]), .b(b[N-1:M]), .p(lh));
            vedic_core #(.N(M)) u_hl (.a(a[N-1:M]), .b(b[M-1:0]), .p(hl));
            vedic_core #(.N(M)) u_hh (.a(a[N-1:M]), .b(b[N-1:M]), .p(hh));
            assign mid = {{N{1'b0}}, lh} + {{N{1'b0}}, hl};
            assign p   = {{N{1'b0}}, ll} + (mid << M) + {hh, {N{1'b0}}};
        end
    endgenerate
endmodule

module vedic_mult_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod
);
    localparam int H = WIDTH / 2;

    // Handshake: a beat moves on a rising edge when valid & ready are both high.
    // The whole pipe advances together whenever the output slot is empty or being taken.
    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign neg_a = in_signed & in_a[WIDTH-1];
    assign neg_b = in_signed & in_b[WIDTH-1];
    // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude
    assign mag_a = neg_a ? -in_a : in_a;
    assign mag_b = neg_b ? -in_b : in_b;

    logic             s1_valid, s1_sign;
    logic [WIDTH-1:0] s1_ma, s1_mb;

    logic             s2_valid, s2_sign;
    logic [WIDTH-1:0] s2_ll, s2_lh, s2_hl, s2_hh;

    logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
    vedic_core #(.N(H)) u_pp_ll (.a(s1_ma[H-1:0]),     .b(s1_mb[H-1:0]),     .p(pp_ll));
    vedic_core #(.N(H)) u_pp_lh (.a(s1_ma[H-1:0]),     .b(s1_mb[WIDTH-1:H]), .p(pp_lh));
    vedic_core #(.N(H)) u_pp_hl (.a(s1_ma[WIDTH-1:H]), .b(s1_mb[H-1:0]),     .p(pp_hl));
    vedic_core #(.N(H)) u_pp_hh (.a(s1_ma[WIDTH-1:H]), .b(s1_mb[WIDTH-1:H]), .p(pp_hh));

    logic [2*WIDTH-1:0] mid_sum, mag_prod, result;
    assign mid_sum  = {{WIDTH{1'b0}}, s2_lh} + {{WIDTH{1'b0}}, s2_hl};
    assign mag_prod = {{WIDTH{1'b0}}, s2_ll} + (mid_sum << H) + {s2_hh, {WIDTH{1'b0}}};
    assign result   = s2_sign ? -mag_prod : mag_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_prod  <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_sign   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            s1_ma     <= mag_a;
            s1_mb     <= mag_b;
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_ll     <= pp_ll;
            s2_lh     <= pp_lh;
            s2_hl     <= pp_hl;
            s2_hh     <= pp_hh;
            out_valid <= s2_valid;
            out_prod  <= result;
        end
    end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe: WIDTH=8 directed/stream/backpressure/reset tests plus
// WIDTH=4 exhaustive and WIDTH=16 corner/random sweeps against an arithmetic model.

module tb_vedic_mult_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        v8, r8, s8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        v4, r4, s4, ov4, or4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        v16, r16, s16, ov16, or16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    vedic_mult_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
        .in_signed(s8), .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(or8), .out_prod(p8));
    vedic_mult_pipe #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4),
        .in_signed(s4), .in_a(a4), .in_b(b4), .out_valid(ov4), .out_ready(or4), .out_prod(p4));
    vedic_mult_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
        .in_signed(s16), .in_a(a16), .in_b(b16), .out_valid(ov16), .out_ready(or16), .out_prod(p16));

    int checks = 0;
    int errors = 0;
    logic [15:0] exp8_q[$];
    logic [7:0]  exp4_q[$];
    logic [31:0] exp16_q[$];
    logic [15:0] got_q[$];
    int taken4 = 0;
    int taken16 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plain integer arithmetic: interpret operands per mode, multiply, wrap to 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input bit s);
        longint m, sa, sb, p;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (s) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp8_q.delete();
            exp4_q.delete();
            exp16_q.delete();
        end else begin
            check("in_ready8", {31'd0, r8}, {31'd0, !ov8 | or8});
            if (ov8) begin
                if (exp8_q.size() == 0) check("spurious8", {31'd0, ov8}, 32'd0);
                else begin
                    check("prod8", {16'd0, p8}, {16'd0, exp8_q[0]});
                    if (or8) begin
                        got_q.push_back(p8);
                        void'(exp8_q.pop_front());
                    end
                end
            end
            if (v8 && r8) exp8_q.push_back(16'(ref_mul(8, {8'd0, a8}, {8'd0, b8}, s8)));

            check("in_ready4", {31'd0, r4}, {31'd0, !ov4 | or4});
            if (ov4) begin
                if (exp4_q.size() == 0) check("spurious4", {31'd0, ov4}, 32'd0);
                else begin
                    check("prod4", {24'd0, p4}, {24'd0, exp4_q[0]});
                    void'(exp4_q.pop_front());
                    taken4++;
                end
            end
            if (v4 && r4) exp4_q.push_back(8'(ref_mul(4, {12'd0, a4}, {12'd0, b4}, s4)));

            check("in_ready16", {31'd0, r16}, {31'd0, !ov16 | or16});
            if (ov16) begin
                if (exp16_q.size() == 0) check("spurious16", {31'd0, ov16}, 32'd0);
                else begin
                    check("prod16", p16, exp16_q[0]);
                    void'(exp16_q.pop_front());
                    taken16++;
                end
            end
            if (v16 && r16) exp16_q.push_back(ref_mul(16, a16, b16, s16));
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        a8 = a; b8 = b; s8 = s; v8 = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = r8;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle8(input int n);
        v8 = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lat8(input logic [15:0] exp_p);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        v8 = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = ov8;
            if (!seen) begin
                @(posedge clk);
                #1;
            end
        end
        check("latency", n, 32'd3);
        check("lat_prod", {16'd0, p8}, {16'd0, exp_p});
        @(posedge clk);
        #1;
    endtask

    logic [15:0] corner16 [5];
    int t0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        corner16 = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        rst = 1'b1;
        v8 = 0; s8 = 0; a8 = 0; b8 = 0; or8 = 1'b1;
        v4 = 0; s4 = 0; a4 = 0; b4 = 0; or4 = 1'b1;
        v16 = 0; s16 = 0; a16 = 0; b16 = 0; or16 = 1'b1;

        check("model_pin_u8", ref_mul(8, 16'h00FF, 16'h00FF, 1'b0), 32'h0000FE01);
        check("model_pin_s4", ref_mul(4, 16'h0008, 16'h0008, 1'b1), 32'h00000040);
        check("model_pin_s16", ref_mul(16, 16'h8000, 16'hFFFF, 1'b1), 32'h00008000);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, ov8}, 32'd0);
        check("rst_out_prod", {16'd0, p8}, 32'd0);
        check("rst_in_ready", {31'd0, r8}, 32'd1);
        rst = 1'b0;

        // 1: unsigned max, latency
        send8(8'hFF, 8'hFF, 1'b0);
        lat8(16'hFE01);
        idle8(2);

        // 2: sign corner cases
        got_q.delete();
        send8(8'h80, 8'h80, 1'b1);
        send8(8'hFF, 8'h7F, 1'b1);
        send8(8'h80, 8'h80, 1'b0);
        idle8(6);
        check("t2_count", got_q.size(), 32'd3);
        if (got_q.size() == 3) begin
            check("t2_s_min_min", {16'd0, got_q[0]}, 32'h4000);
            check("t2_s_m1_x7f", {16'd0, got_q[1]}, 32'hFF81);
            check("t2_u_80_80", {16'd0, got_q[2]}, 32'h4000);
        end

        // 3: back-to-back random stream
        got_q.delete();
        t0 = cyc;
        for (int i = 0; i < 256; i++)
            send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        check("t3_cycles", cyc - t0, 32'd256);
        idle8(6);
        check("t3_count", got_q.size(), 32'd256);

        // 4: stall with a full pipe and a waiting beat
        got_q.delete();
        send8(8'h03, 8'h05, 1'b0);
        send8(8'hFF, 8'h02, 1'b1);
        send8(8'h7F, 8'h7F, 1'b1);
        or8 = 1'b0;
        a8 = 8'h10; b8 = 8'h10; s8 = 1'b0; v8 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t4_in_ready", {31'd0, r8}, 32'd0);
            check("t4_out_valid", {31'd0, ov8}, 32'd1);
            check("t4_hold", {16'd0, p8}, 32'h000F);
            @(posedge clk);
            #1;
        end
        or8 = 1'b1;
        @(posedge clk);
        #1;
        idle8(6);
        check("t4_count", got_q.size(), 32'd4);
        if (got_q.size() == 4) begin
            check("t4_b0", {16'd0, got_q[0]}, 32'h000F);
            check("t4_b1", {16'd0, got_q[1]}, 32'hFFFE);
            check("t4_b2", {16'd0, got_q[2]}, 32'h3F01);
            check("t4_b3", {16'd0, got_q[3]}, 32'h0100);
        end

        // 5: reset with beats in flight
        send8(8'h01, 8'h02, 1'b0);
        send8(8'h03, 8'h04, 1'b0);
        send8(8'h05, 8'h06, 1'b0);
        v8 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_out_valid", {31'd0, ov8}, 32'd0);
        check("t5_out_prod", {16'd0, p8}, 32'd0);
        check("t5_in_ready", {31'd0, r8}, 32'd1);
        @(posedge clk);
        #1;
        got_q.delete();
        send8(8'h0A, 8'h0B, 1'b0);
        lat8(16'h006E);
        idle8(4);
        check("t5_count", got_q.size(), 32'd1);

        // 6a: WIDTH=4 exhaustive, both modes
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    a4 = 4'(a); b4 = 4'(b); s4 = 1'(s); v4 = 1'b1;
                    @(posedge clk);
                    #1;
                end
        v4 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t6_count4", taken4, 32'd512);

        // 6b: WIDTH=16 corners then random
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) begin
                    a16 = corner16[i]; b16 = corner16[j]; s16 = 1'(s); v16 = 1'b1;
                    @(posedge clk);
                    #1;
                end
        for (int i = 0; i < 150; i++) begin
            a16 = 16'($urandom_range(0, 65535));
            b16 = 16'($urandom_range(0, 65535));
            s16 = 1'($urandom_range(0, 1));
            v16 = 1'b1;
            @(posedge clk);
            #1;
        end
        v16 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t6_count16", taken16, 32'd200);

        check("drain8", exp8_q.size(), 32'd0);
        check("drain4", exp4_q.size(), 32'd0);
        check("drain16", exp16_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
